uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 11 +
 rtl/rr_picker.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The arbiter FSM has two states: IDLE (arbitrating) and LOCKED (one requester owns the link).
package uart_arb_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int BYTE_W          = 8;
  localparam int TIMEOUT_DEFAULT = 1024;
endpackage

// File: rtl/rr_picker.sv
// Rotating-priority selector: returns the first asserted index at or after i_rr_ptr,
// wrapping modulo NREQ. o_idx is only meaningful while o_any_valid is high.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_rr_ptr,
  output logic [IW-1:0]   o_idx,
  output logic            o_any_valid
);
  logic [IW-1:0] w_cand;

  // Walk the offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    o_idx  = '0;
    w_cand = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      w_cand = IW'((int'(i_rr_ptr) + off) % NREQ);
      if (i_valid[w_cand]) o_idx = w_cand;
    end
  end

  assign o_any_valid = |i_valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one requester's byte stream onto a UART transmit stream
// until that requester sends its last byte or stalls for too long.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ*BYTE_W-1:0] req_tdata,
  input  logic [NREQ-1:0]        req_tvalid,
  input  logic [NREQ-1:0]        req_tlast,
  output logic [NREQ-1:0]        req_tready,
  output logic [BYTE_W-1:0]      tx_tdata,
  output logic                   tx_tvalid,
  input  logic                   tx_tready,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   timeout_err
);
  // Handshake: a byte moves on any cycle where valid and ready are both high at the
  // rising edge. Valid never waits on ready; ready may depend on valid.

  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(TIMEOUT) + 1;
  localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NREQ - 1);

  arb_state_t          r_state, w_state_nxt;
  logic [NREQ-1:0]     r_grant, w_grant_nxt;
  logic [IW-1:0]       r_gidx, w_gidx_nxt;
  logic [IW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0]       w_gidx_inc, w_pick_idx;
  logic [SW-1:0]       r_stall, w_stall_nxt, w_stall_inc;
  logic                r_timeout, w_timeout_nxt;
  logic [BYTE_W-1:0]   r_tx_data, w_g_data;
  logic                r_tx_valid;
  logic                w_g_valid, w_g_last;
  logic                w_out_ready, w_accept, w_any_valid;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .i_valid     (req_tvalid),
    .i_rr_ptr    (r_rr_ptr),
    .o_idx       (w_pick_idx),
    .o_any_valid (w_any_valid)
  );

  // Route the granted requester's lane.
  always_comb begin
    w_g_data  = '0;
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gidx == IW'(i)) begin
        w_g_data  = req_tdata[i*BYTE_W +: BYTE_W];
        w_g_valid = req_tvalid[i];
        w_g_last  = req_tlast[i];
      end
    end
  end

  // The output register can take a byte when empty or when it drains this cycle.
  assign w_out_ready = ~r_tx_valid | tx_tready;
  assign w_accept    = (r_state == LOCKED) & w_g_valid & w_out_ready;
  assign w_gidx_inc  = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;
  assign w_stall_inc = r_stall + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_gidx_nxt    = r_gidx;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_stall_nxt   = r_stall;
    w_timeout_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          w_state_nxt = LOCKED;
          w_gidx_nxt  = w_pick_idx;
          w_grant_nxt = NREQ'(1) << w_pick_idx;
          w_stall_nxt = '0;
        end
      end
      LOCKED: begin
        if (w_accept) begin
          w_stall_nxt = '0;
          if (w_g_last) begin
            w_state_nxt  = IDLE;
            w_grant_nxt  = '0;
            w_rr_ptr_nxt = w_gidx_inc;
          end
        end else if (w_stall_inc == STALL_LIMIT) begin
          // Forced release; whatever sits in the output register still drains.
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_rr_ptr_nxt  = w_gidx_inc;
          w_stall_nxt   = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_stall_nxt = w_stall_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_rr_ptr  <= '0;
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_gidx    <= w_gidx_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_stall   <= w_stall_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_accept) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_g_data;
    end else if (tx_tready) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign req_tready  = ((r_state == LOCKED) && w_out_ready) ? r_grant : '0;
  assign tx_tdata    = r_tx_data;
  assign tx_tvalid   = r_tx_valid;
  assign grant       = r_grant;
  assign busy        = (r_state == LOCKED);
  assign timeout_err = r_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, all checked
// against a message-level reference model and an expected-byte queue.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR*8-1:0] req_tdata;
  logic [NR-1:0]   req_tvalid, req_tlast, req_tready;
  logic [7:0]      tx_tdata;
  logic            tx_tvalid, tx_tready;
  logic [NR-1:0]   grant;
  logic            busy, timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NR), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_tdata   (req_tdata),
    .req_tvalid  (req_tvalid),
    .req_tlast   (req_tlast),
    .req_tready  (req_tready),
    .tx_tdata    (tx_tdata),
    .tx_tvalid   (tx_tvalid),
    .tx_tready   (tx_tready),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-requester byte queues (head/tail into fixed arrays).
  logic [7:0] dmem  [NR][256];
  logic       dlast [NR][256];
  int         dhead [NR];
  int         dtail [NR];
  int         gap   [NR];
  logic [7:0] drv_data [NR];
  int         tready_mode;
  logic       prev_tready;
  bit         rand_gaps;
  logic [NR-1:0] acc_obs;

  // Reference model state and scoreboard.
  int         m_owner, m_ptr, m_stall;
  logic       m_txv, m_to;
  logic [7:0] exp_q[$];

  // Event logs used by the directed scenarios.
  int         cyc;
  int         grant_log[$];
  logic [NR-1:0] prev_grant;
  int         first_vld_cyc, first_txv_cyc, to_cyc, to_cnt;
  int         hs_first, hs_last, hs_cnt;
  int         acc_cyc [NR];
  bit         bp_check;

  function automatic int oh_idx(input logic [NR-1:0] g);
    oh_idx = -1;
    for (int i = 0; i < NR; i++) if (g[i]) oh_idx = i;
  endfunction

  function automatic bit all_idle();
    all_idle = (m_owner < 0) && !m_txv;
    for (int i = 0; i < NR; i++) if (dhead[i] != dtail[i]) all_idle = 0;
  endfunction

  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    if (dtail[r] < 256) begin
      dmem[r][dtail[r]]  = d;
      dlast[r][dtail[r]] = l;
      dtail[r]++;
    end
  endtask

  task automatic clear_drv();
    for (int i = 0; i < NR; i++) begin
      dhead[i] = 0;
      dtail[i] = 0;
      gap[i]   = 0;
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_ptr      = 0;
    m_stall    = 0;
    m_txv      = 1'b0;
    m_to       = 1'b0;
    prev_grant = '0;
    exp_q.delete();
  endtask

  task automatic drive_inputs();
    logic v;
    for (int i = 0; i < NR; i++) begin
      v = (dhead[i] < dtail[i]) && (gap[i] == 0);
      req_tvalid[i]      = v;
      req_tdata[i*8 +: 8] = v ? dmem[i][dhead[i]] : 8'h00;
      req_tlast[i]       = v ? dlast[i][dhead[i]] : 1'b0;
      drv_data[i]        = req_tdata[i*8 +: 8];
    end
    case (tready_mode)
      0:       tx_tready = 1'b1;
      1:       tx_tready = prev_tready ? ($urandom_range(0, 3) != 0) : 1'b1;
      default: tx_tready = 1'b0;
    endcase
    prev_tready = tx_tready;
    if (first_vld_cyc < 0 && req_tvalid != '0) first_vld_cyc = cyc;
  endtask

  task automatic sample_and_model();
    logic [NR-1:0] exp_grant, exp_rdy;
    logic rdy_ok, m_acc;
    int w;
    exp_grant = (m_owner < 0) ? '0 : NR'(1) << m_owner;
    rdy_ok    = !m_txv || tx_tready;
    exp_rdy   = (m_owner >= 0 && rdy_ok) ? exp_grant : '0;
    check_eq("grant", 32'(grant), 32'(exp_grant));
    check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    check_eq("tx_tvalid", 32'(tx_tvalid), 32'(m_txv));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_to));
    check_eq("req_tready", 32'(req_tready), 32'(exp_rdy));
    if (m_txv && exp_q.size() > 0) check_eq("tx_tdata", 32'(tx_tdata), 32'(exp_q[0]));
    if (bp_check) begin
      check_eq("bp_data", 32'(tx_tdata), 32'h55);
      check_eq("bp_rdy", 32'(req_tready), 32'h0);
    end

    acc_obs = req_tvalid & req_tready;
    if (grant != '0 && grant != prev_grant) grant_log.push_back(oh_idx(grant));
    prev_grant = grant;
    if (tx_tvalid && first_txv_cyc < 0) first_txv_cyc = cyc;
    if (timeout_err) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (tx_tvalid && tx_tready) begin
      if (hs_first < 0) hs_first = cyc;
      hs_last = cyc;
      hs_cnt++;
    end
    for (int i = 0; i < NR; i++) if (acc_obs[i]) acc_cyc[i] = cyc;

    // Advance the model by one cycle using the bench's own drive values.
    m_acc = (m_owner >= 0) && req_tvalid[m_owner] && rdy_ok;
    if (m_txv && tx_tready) void'(exp_q.pop_front());
    if (m_acc) exp_q.push_back(drv_data[m_owner]);
    m_txv = m_acc ? 1'b1 : (tx_tready ? 1'b0 : m_txv);
    m_to  = 1'b0;
    if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < NR; k++) if (w < 0 && req_tvalid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      if (w >= 0) begin
        m_owner = w;
        m_stall = 0;
      end
    end else if (m_acc) begin
      m_stall = 0;
      if (req_tlast[m_owner]) begin
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end else begin
      m_stall++;
      if (m_stall == TO - 1) begin
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
        m_stall = 0;
        m_to    = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    drive_inputs();
    #1;
    sample_and_model();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (gap[i] > 0) gap[i]--;
      if (acc_obs[i]) begin
        dhead[i]++;
        if (rand_gaps) gap[i] = $urandom_range(0, 1);
      end
    end
    cyc++;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    while (!all_idle() && n < max_cycles) begin
      cycle();
      n++;
    end
    check_eq("drain", 32'(all_idle()), 32'h1);
  endtask

  task automatic run_random(input int n_msgs);
    int msgs, budget, len;
    msgs   = 0;
    budget = 0;
    while (msgs < n_msgs && budget < 3000) begin
      for (int i = 0; i < NR; i++) begin
        if (dhead[i] == dtail[i] && msgs < n_msgs && $urandom_range(0, 5) == 0) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
          msgs++;
        end
      end
      cycle();
      budget++;
    end
    run_until_idle(400);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_tdata = '0; req_tvalid = '0; req_tlast = '0; tx_tready = 1'b1;
    prev_tready = 1'b1; tready_mode = 0; rand_gaps = 0; bp_check = 0;
    cyc = 0; to_cnt = 0; to_cyc = 0; first_vld_cyc = -1; first_txv_cyc = -1;
    hs_first = -1; hs_last = -1; hs_cnt = 0;
    for (int i = 0; i < NR; i++) acc_cyc[i] = 0;
    clear_drv();
    model_reset();

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_txv", 32'(tx_tvalid), 32'h0);
    check_eq("rst_txd", 32'(tx_tdata), 32'h0);
    check_eq("rst_rdy", 32'(req_tready), 32'h0);
    check_eq("rst_to", 32'(timeout_err), 32'h0);
    rst = 1'b0;

    // Contention from reset: grants go 0,1,2,3 with whole messages back to back
    grant_log.delete();
    for (int i = 0; i < NR; i++) begin
      push_byte(i, 8'(8'hA0 + i * 16), 1'b0);
      push_byte(i, 8'(8'hA1 + i * 16), 1'b1);
    end
    run_until_idle(60);
    cycle();
    check_eq("cont_n", grant_log.size(), 4);
    for (int i = 0; i < NR; i++) if (i < grant_log.size()) check_eq("cont_order", grant_log[i], i);

    // Single requester, 3-byte message, latency and consecutive delivery
    grant_log.delete();
    first_vld_cyc = -1; first_txv_cyc = -1; hs_first = -1; hs_cnt = 0;
    push_byte(1, 8'h41, 1'b0);
    push_byte(1, 8'h42, 1'b0);
    push_byte(1, 8'h43, 1'b1);
    run_until_idle(40);
    cycle();
    check_eq("single_lat", first_txv_cyc - first_vld_cyc, 2);
    check_eq("single_hs", hs_cnt, 3);
    check_eq("single_span", hs_last - hs_first, 2);
    check_eq("single_gnt_n", grant_log.size(), 1);
    if (grant_log.size() > 0) check_eq("single_gnt", grant_log[0], 1);

    // Backpressure: output byte held and requester blocked
    tready_mode = 2;
    push_byte(0, 8'h55, 1'b0);
    push_byte(0, 8'h66, 1'b1);
    cycle();
    cycle();
    bp_check = 1;
    repeat (5) cycle();
    bp_check = 0;
    tready_mode = 0;
    run_until_idle(40);
    cycle();

    // Stall timeout: one byte without tlast, then valid drops
    to_cnt = 0;
    grant_log.delete();
    push_byte(2, 8'h10, 1'b0);
    repeat (4) cycle();
    push_byte(0, 8'h20, 1'b1);
    push_byte(3, 8'h30, 1'b1);
    run_until_idle(60);
    cycle();
    check_eq("to_cnt", to_cnt, 1);
    check_eq("to_delay", to_cyc - acc_cyc[2], 8);
    check_eq("to_order_n", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check_eq("to_order0", grant_log[0], 2);
      check_eq("to_order1", grant_log[1], 3);
      check_eq("to_order2", grant_log[2], 0);
    end

    // Reset in the middle of a message
    tready_mode = 2;
    push_byte(0, 8'h71, 1'b0);
    push_byte(0, 8'h72, 1'b0);
    push_byte(0, 8'h73, 1'b1);
    repeat (3) cycle();
    check_eq("mid_pre_txv", 32'(tx_tvalid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_grant", 32'(grant), 32'h0);
    check_eq("mid_busy", 32'(busy), 32'h0);
    check_eq("mid_txv", 32'(tx_tvalid), 32'h0);
    check_eq("mid_txd", 32'(tx_tdata), 32'h0);
    check_eq("mid_rdy", 32'(req_tready), 32'h0);
    check_eq("mid_to", 32'(timeout_err), 32'h0);
    clear_drv();
    model_reset();
    tready_mode = 0;
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hs_cnt = 0;
    push_byte(0, 8'h81, 1'b0);
    push_byte(0, 8'h82, 1'b0);
    push_byte(0, 8'h83, 1'b1);
    run_until_idle(40);
    cycle();
    check_eq("post_rst_hs", hs_cnt, 3);

    // Randomized traffic with gaps and bursty tx_tready
    clear_drv();
    tready_mode = 1;
    rand_gaps = 1;
    run_random(60);
    tready_mode = 0;
    rand_gaps = 0;
    repeat (2) cycle();
    check_eq("final_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
